// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined multiply cell with credit-checked, ID-tagged response FIFO
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [32*NUM_REQ-1:0]      req_src1,
  input  logic [32*NUM_REQ-1:0]      req_src2,
  output logic [31:0]                mul_src1,
  output logic [31:0]                mul_src2,
  input  logic [31:0]                mul_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [31:0]                resp_result,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RESP_DEPTH + 1) + 1;
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  logic [IW-1:0] ptr, gnt_idx, last_id;
  logic found, issue_ok, push, pop;
  logic [CW-1:0] fifo_count, inflight_count;
  logic [31:0] last_src1, last_src2, last_res;
  logic [MUL_LATENCY-1:0] tag_v;
  logic [IW-1:0] tag_id [MUL_LATENCY];
  logic [IW-1:0] mem_id [RESP_DEPTH];
  logic [31:0] mem_res [RESP_DEPTH];
  logic [PW-1:0] rp, wp;
  // Credits count only registered occupancy, so a pop frees a slot one cycle later
  assign issue_ok = !reset && (fifo_count + inflight_count < CW'(RESP_DEPTH));
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!found && issue_ok && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign req_ready = found ? NUM_REQ'(1) << gnt_idx : '0;
  assign mul_src1 = found ? req_src1[32*int'(gnt_idx) +: 32] : last_src1;
  assign mul_src2 = found ? req_src2[32*int'(gnt_idx) +: 32] : last_src2;
  assign push = tag_v[MUL_LATENCY-1];
  assign resp_valid = fifo_count != '0;
  assign pop = resp_valid && resp_ready;
  assign resp_id = resp_valid ? mem_id[rp] : last_id;
  assign resp_result = resp_valid ? mem_res[rp] : last_res;
  assign busy = resp_valid || inflight_count != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IW'(NUM_REQ - 1);
      last_src1 <= '0;
      last_src2 <= '0;
      last_res <= '0;
      last_id <= '0;
      tag_v <= '0;
      fifo_count <= '0;
      inflight_count <= '0;
      rp <= '0;
      wp <= '0;
    end else begin
      if (found) begin
        ptr <= gnt_idx;
        last_src1 <= mul_src1;
        last_src2 <= mul_src2;
      end
      tag_v <= (tag_v << 1) | MUL_LATENCY'(found);
      inflight_count <= inflight_count + CW'(found) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wp <= wp == PW'(RESP_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) begin
        rp <= rp == PW'(RESP_DEPTH - 1) ? '0 : rp + 1'b1;
        last_id <= mem_id[rp];
        last_res <= mem_res[rp];
      end
    end
  end
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_idx;
    for (int s = 1; s < MUL_LATENCY; s++) tag_id[s] <= tag_id[s-1];
    if (push) begin
      mem_id[wp] <= tag_id[MUL_LATENCY-1];
      mem_res[wp] <= mul_result;
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for the shared multiplier arbiter (L=1 and L=3 instances)
module tb_mul_share_arbiter;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, resp_ready = 0, resp_valid, busy;
  logic [3:0] req_valid = 0, req_ready;
  logic [127:0] req_src1 = 0, req_src2 = 0;
  logic [31:0] mul_src1, mul_src2, mul_result, resp_result;
  logic [1:0] resp_id;
  logic b_resp_ready = 1, b_resp_valid, b_busy;
  logic [3:0] b_valid = 0, b_req_ready;
  logic [127:0] b_src1 = 0, b_src2 = 0;
  logic [31:0] b_mul_src1, b_mul_src2, b_mul_result, b_resp_result;
  logic [1:0] b_resp_id;
  int checks = 0, errors = 0, n_resp = 0;

  mul_share_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_result(mul_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .busy(busy));

  mul_share_arbiter #(.NUM_REQ(4), .MUL_LATENCY(3), .RESP_DEPTH(5)) dut_l3 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_req_ready),
    .req_src1(b_src1), .req_src2(b_src2), .mul_src1(b_mul_src1), .mul_src2(b_mul_src2),
    .mul_result(b_mul_result), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_id(b_resp_id), .resp_result(b_resp_result), .busy(b_busy));

  // Multiply cell models: product of the operands presented L cycles earlier
  logic [31:0] cell1;
  logic [31:0] cell3 [3];
  always @(posedge clk) begin
    cell1 <= mul_src1 * mul_src2;
    cell3[0] <= b_mul_src1 * b_mul_src2;
    cell3[1] <= cell3[0];
    cell3[2] <= cell3[1];
  end
  assign mul_result = cell1;
  assign b_mul_result = cell3[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [1:0] id; logic [31:0] res;} exp_t;
  exp_t q[$];
  exp_t e;
  int gnt_log[$];
  logic [31:0] last_pop = 0;

  always @(negedge clk) begin
    if (reset) q.delete();
    else begin
      chk("onehot", 64'($countones(req_ready) <= 1), 1);
      chk("ready_wo_valid", 64'(|(req_ready & ~req_valid)), 0);
      chk("fifo_bound", 64'(dut.fifo_count <= 4), 1);
      for (int i = 0; i < 4; i++)
        if (req_ready[i]) begin
          q.push_back({2'(i), req_src1[32*i +: 32] * req_src2[32*i +: 32]});
          gnt_log.push_back(i);
        end
      if (resp_valid && resp_ready) begin
        n_resp++;
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_result", 64'(resp_result), 64'(e.res));
          last_pop = resp_result;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    req_valid = 0;
    cyc(2);
    reset = 0;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
  endtask

  logic [31:0] held;
  int seen, base;

  initial begin
    do_reset();
    resp_ready = 1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_id", 64'(resp_id), 0);
    chk("rst_resp_result", 64'(resp_result), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mul_src1", 64'(mul_src1), 0);
    chk("rst_mul_src2", 64'(mul_src2), 0);
    // single op
    set_op(0, 32'h0001_0003, 32'h0000_0005);
    req_valid = 4'b0001;
    #1 chk("single_grant", 64'(req_ready), 1);
    cyc();
    req_valid = 0;
    #1 chk("single_t1_valid", 64'(resp_valid), 0);
    chk("single_t1_busy", 64'(busy), 1);
    chk("single_hold_src1", 64'(mul_src1), 64'h0001_0003);
    cyc();
    chk("single_t2_valid", 64'(resp_valid), 1);
    chk("single_t2_id", 64'(resp_id), 0);
    chk("single_t2_result", 64'(resp_result), 64'h0005_000F);
    cyc();
    chk("empty_valid", 64'(resp_valid), 0);
    chk("empty_hold_result", 64'(resp_result), 64'h0005_000F);
    // round robin
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 2), 32'd10);
    base = n_resp;
    req_valid = 4'hF;
    cyc(5);
    req_valid = 0;
    cyc(6);
    chk("rr_grants", 64'(gnt_log.size()), 5);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("rr_order", 64'(gnt_log[k]), 64'(k % 4));
    chk("rr_responses", 64'(n_resp - base), 5);
    // backpressure
    do_reset();
    resp_ready = 0;
    gnt_log.delete();
    set_op(1, 32'd7, 32'd3);
    req_valid = 4'b0010;
    cyc(10);
    chk("bp_grants", 64'(gnt_log.size()), 4);
    chk("bp_ready_low", 64'(req_ready), 0);
    chk("bp_resp_valid", 64'(resp_valid), 1);
    chk("bp_head", 64'(resp_result), 21);
    held = resp_result;
    cyc(2);
    chk("bp_stable", 64'(resp_result), 64'(held));
    resp_ready = 1;
    #1 chk("bp_no_same_cycle_credit", 64'(req_ready), 0);
    cyc();
    resp_ready = 0;
    #1 chk("bp_regrant", 64'(req_ready), 64'b0010);
    cyc();
    chk("bp_ready_low2", 64'(req_ready), 0);
    chk("bp_grants2", 64'(gnt_log.size()), 5);
    req_valid = 0;
    resp_ready = 1;
    cyc(8);
    chk("bp_drained", 64'(q.size()), 0);
    // wrap arithmetic
    set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b1000;
    cyc();
    req_valid = 0;
    cyc(3);
    chk("wrap_ones", 64'(last_pop), 1);
    set_op(3, 32'h0001_0000, 32'h0001_0000);
    req_valid = 4'b1000;
    cyc();
    req_valid = 0;
    cyc(3);
    chk("wrap_zero", 64'(last_pop), 0);
    // reset mid-flight
    req_valid = 4'b0100;
    #1 chk("mid_grant2", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = 0;
    reset = 1;
    cyc(2);
    reset = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      seen += int'(resp_valid);
      cyc();
    end
    chk("mid_no_resp", 64'(seen), 0);
    chk("mid_busy", 64'(busy), 0);
    req_valid = 4'hF;
    #1 chk("mid_first_grant", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = 0;
    cyc(5);
    // latency sweep on the L=3 / depth 5 instance
    for (int c = 0; c < 11; c++) begin
      b_valid = {3'b000, c < 6};
      b_src1[31:0] = 32'(c + 1);
      b_src2[31:0] = 32'd7;
      #1;
      if (c < 6) chk("lat_grant", 64'(b_req_ready), 1);
      chk("lat_valid", 64'(b_resp_valid), 64'(c >= 4 && c < 10));
      if (c >= 4 && c < 10) begin
        chk("lat_result", 64'(b_resp_result), 64'((c - 3) * 7));
        chk("lat_id", 64'(b_resp_id), 0);
      end
      chk("lat_busy", 64'(b_busy), 64'(c >= 1 && c <= 9));
      cyc();
    end
    chk("sb_drained", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
